// File: rtl/alu_instr_sequencer.sv
// Instruction FIFO plus READ/WRITE issue engine driving an ALU_RegFile datapath.
// Optional retirement counter port enabled by defining ALU_SEQ_PERF_CNT_EN.
module alu_instr_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [10:0] instr_data,
  output logic        instr_ready,
  output logic [2:0]  read_reg1,
  output logic [2:0]  read_reg2,
  output logic [2:0]  write_reg,
  output logic [1:0]  opcode,
  output logic        reg_write,
  input  logic [7:0]  alu_result,
  output logic        result_valid,
  output logic [7:0]  result_data,
  output logic [2:0]  result_rd,
  output logic        busy
`ifdef ALU_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_t       state;
  logic [10:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]  count;
  logic         push;
  logic         pop;
  logic [10:0]  head;

  assign instr_ready = (count != FULL_COUNT);
  assign push        = instr_valid && instr_ready;
  // The head is consumed on every edge that enters READ, i.e. from IDLE or WRITE.
  assign pop         = (state != READ) && (count != '0);
  assign head        = mem[rd_ptr];
  assign busy        = (state != IDLE) || (count != '0);

  // NOTE: storage array is deliberately not reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      read_reg1    <= '0;
      read_reg2    <= '0;
      write_reg    <= '0;
      opcode       <= '0;
      reg_write    <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
      result_rd    <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= READ;
            opcode    <= head[10:9];
            write_reg <= head[8:6];
            read_reg1 <= head[5:3];
            read_reg2 <= head[2:0];
          end
        end
        READ: begin
          state     <= WRITE;
          reg_write <= 1'b1;
        end
        WRITE: begin
          reg_write    <= 1'b0;
          result_data  <= alu_result;
          result_rd    <= write_reg;
          result_valid <= 1'b1;
          if (pop) begin
            state     <= READ;
            opcode    <= head[10:9];
            write_reg <= head[8:6];
            read_reg1 <= head[5:3];
            read_reg2 <= head[2:0];
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              retired_cnt <= '0;
    else if (state == WRITE) retired_cnt <= retired_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomized bench for alu_instr_sequencer with a register-file stand-in and an
// in-order program model predicting each result.
module tb_alu_instr_sequencer;

  typedef struct {logic [7:0] data; logic [2:0] rd;} exp_t;
  typedef struct {logic [7:0] data; logic [2:0] rd; int cyc;} obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [10:0] instr_data = '0;
  logic        instr_ready;
  logic [2:0]  read_reg1, read_reg2, write_reg;
  logic [1:0]  opcode;
  logic        reg_write;
  logic [7:0]  alu_result;
  logic        result_valid;
  logic [7:0]  result_data;
  logic [2:0]  result_rd;
  logic        busy;
`ifdef ALU_SEQ_PERF_CNT_EN
  logic [15:0] retired_cnt;
`endif

  logic [7:0]  rf  [8];
  logic [7:0]  mrf [8];
  logic        pre_we = 1'b0;
  logic [2:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   stalls = 0;

  alu_instr_sequencer #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .write_reg(write_reg),
    .opcode(opcode), .reg_write(reg_write), .alu_result(alu_result),
    .result_valid(result_valid), .result_data(result_data), .result_rd(result_rd),
    .busy(busy)
`ifdef ALU_SEQ_PERF_CNT_EN
    , .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Register-file stand-in: combinational read, write at the end of the WRITE cycle.
  assign alu_result = alu_f(opcode, rf[read_reg1], rf[read_reg2]);
  always @(posedge clk) begin
    if (pre_we)         rf[pre_addr]  <= pre_data;
    else if (reg_write) rf[write_reg] <= alu_result;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && result_valid) obs_q.push_back('{result_data, result_rd, cyc});
  end

  function automatic logic [10:0] enc(input int op, input int rd, input int rs1, input int rs2);
    return {2'(op), 3'(rd), 3'(rs1), 3'(rs2)};
  endfunction

  task automatic preload(input int addr, input logic [7:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 3'(addr); pre_data = val;
    mrf[addr] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Drives one instruction until handshaken; the program model executes it on acceptance.
  task automatic push_instr(input logic [10:0] d, output bit ok);
    int budget;
    logic [7:0] r;
    budget = 0;
    ok = 1'b0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = d;
    while (!instr_ready && budget < 50) begin
      @(negedge clk);
      budget++;
      stalls++;
    end
    if (instr_ready) begin
      @(posedge clk);
      ok = 1'b1;
      r = alu_f(d[10:9], mrf[d[5:3]], mrf[d[2:0]]);
      mrf[d[8:6]] = r;
      exp_q.push_back('{r, d[8:6]});
    end
  endtask

  task automatic release_valid();
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, output bit ok);
    int budget;
    budget = 0;
    while (obs_q.size() < n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    #12;
    chk_cnt++; if ({instr_ready, reg_write, result_valid, busy} !== 4'b1000)
      $display("FAIL reset_ctrl: got %b expected 1000", {instr_ready, reg_write, result_valid, busy});
    else pass_cnt++;
    chk_cnt++; if ({read_reg1, read_reg2, write_reg, opcode} !== 11'd0)
      $display("FAIL reset_fields: got %h expected 000", {read_reg1, read_reg2, write_reg, opcode});
    else pass_cnt++;
    chk_cnt++; if ({result_data, result_rd} !== 11'd0)
      $display("FAIL reset_result: got %h expected 000", {result_data, result_rd});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    for (int i = 0; i < 8; i++) preload(i, (i == 0) ? 8'h0F : (i == 1) ? 8'hF0 : 8'h00);
    obs_q.delete(); exp_q.delete();
    push_instr(enc(0, 2, 0, 1), ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL single_accept: got %b expected 1", ok); else pass_cnt++;
    @(negedge clk);
    instr_valid = 1'b0;
    chk_cnt++; if ({busy, reg_write} !== 2'b10)
      $display("FAIL single_idle: got %b expected 10", {busy, reg_write});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({read_reg1, read_reg2, write_reg, opcode, reg_write} !== {3'd0, 3'd1, 3'd2, 2'd0, 1'b0})
      $display("FAIL single_read: got %h expected %h", {read_reg1, read_reg2, write_reg, opcode, reg_write}, {3'd0, 3'd1, 3'd2, 2'd0, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({reg_write, write_reg, result_valid} !== {1'b1, 3'd2, 1'b0})
      $display("FAIL single_write: got %b expected 10100", {reg_write, write_reg, result_valid});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({result_valid, result_data, result_rd, reg_write} !== {1'b1, 8'h00, 3'd2, 1'b0})
      $display("FAIL single_result: got %h expected %h", {result_valid, result_data, result_rd, reg_write}, {1'b1, 8'h00, 3'd2, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({result_valid, busy} !== 2'b00)
      $display("FAIL single_strobe_end: got %b expected 00", {result_valid, busy});
    else pass_cnt++;
    chk_cnt++; if (rf[2] !== 8'h00) $display("FAIL single_rf_write: got %h expected 00", rf[2]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int ops[4] = '{1, 2, 3, 0};
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      push_instr(enc(ops[i], 3 + i, 0, 1), ok);
    end
    release_valid();
    wait_results(4, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL b2b_timeout: got %0d results expected 4", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++; if ({obs_q[i].data, obs_q[i].rd} !== {exp_q[i].data, exp_q[i].rd})
        $display("FAIL b2b_result%0d: got %h/%0d expected %h/%0d", i, obs_q[i].data, obs_q[i].rd, exp_q[i].data, exp_q[i].rd);
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++; if (obs_q[i].cyc - obs_q[i-1].cyc !== 2)
          $display("FAIL b2b_spacing%0d: got %0d expected 2", i, obs_q[i].cyc - obs_q[i-1].cyc);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_dependency();
    bit ok;
    obs_q.delete(); exp_q.delete();
    push_instr(enc(1, 2, 0, 1), ok);
    push_instr(enc(0, 3, 2, 0), ok);
    release_valid();
    wait_results(2, ok);
    chk_cnt++; if (ok !== 1'b1) $display("FAIL dep_timeout: got %0d results expected 2", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++; if ({obs_q[i].data, obs_q[i].rd} !== {exp_q[i].data, exp_q[i].rd})
        $display("FAIL dep_result%0d: got %h/%0d expected %h/%0d", i, obs_q[i].data, obs_q[i].rd, exp_q[i].data, exp_q[i].rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int pushed;
    obs_q.delete(); exp_q.delete();
    stalls = 0;
    pushed = 0;
    for (int i = 0; i < 12; i++) begin
      push_instr(11'($urandom), ok);
      if (ok) pushed++;
    end
    release_valid();
    chk_cnt++; if (pushed !== 12) $display("FAIL bp_accepted: got %0d expected 12", pushed); else pass_cnt++;
    chk_cnt++; if (stalls == 0) $display("FAIL bp_ready_low: got %0d stall cycles expected >0", stalls); else pass_cnt++;
    wait_results(12, ok);
    repeat (20) @(negedge clk);
    chk_cnt++; if (obs_q.size() !== 12) $display("FAIL bp_count: got %0d expected 12", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++; if ({obs_q[i].data, obs_q[i].rd} !== {exp_q[i].data, exp_q[i].rd})
        $display("FAIL bp_result%0d: got %h/%0d expected %h/%0d", i, obs_q[i].data, obs_q[i].rd, exp_q[i].data, exp_q[i].rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int i = 0; i < 8; i++) preload(i, 8'($urandom));
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      push_instr(11'($urandom), ok);
      if ($urandom_range(0, 2) == 0) begin
        release_valid();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    release_valid();
    wait_results(30, ok);
    chk_cnt++; if (obs_q.size() !== 30) $display("FAIL rand_count: got %0d expected 30", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk_cnt++; if ({obs_q[i].data, obs_q[i].rd} !== {exp_q[i].data, exp_q[i].rd})
        $display("FAIL rand_result%0d: got %h/%0d expected %h/%0d", i, obs_q[i].data, obs_q[i].rd, exp_q[i].data, exp_q[i].rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int budget;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) push_instr(11'($urandom), ok);
    release_valid();
    budget = 0;
    while (!reg_write && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk_cnt++; if (reg_write !== 1'b1) $display("FAIL rstmid_reach_write: got %b expected 1", reg_write); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++; if ({reg_write, busy, instr_ready, result_valid} !== 4'b0010)
      $display("FAIL rstmid_async: got %b expected 0010", {reg_write, busy, instr_ready, result_valid});
    else pass_cnt++;
    obs_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk_cnt++; if (obs_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL rstmid_discard: got %0d results busy=%b expected 0 results busy=0", obs_q.size(), busy);
    else pass_cnt++;
  endtask

`ifdef ALU_SEQ_PERF_CNT_EN
  task automatic test_perf();
    bit ok;
    for (int i = 0; i < 8; i++) preload(i, 8'($urandom));
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) push_instr(11'($urandom), ok);
    release_valid();
    wait_results(5, ok);
    repeat (4) @(negedge clk);
    chk_cnt++; if (retired_cnt !== 16'd5) $display("FAIL perf_count: got %0d expected 5", retired_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_dependency();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef ALU_SEQ_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
